// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 16-bit pipelined processor.
//
// Purpose:
//   Selects the forwarded A/B operands, computes single-cycle ALU results
//   and runs a 16-step shift-add multiplier for MUL. It also owns the
//   EX/MEM pipeline register that feeds the MEM stage.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   PCE_i, rd1E_i, rd2E_i,   instruction fields and register operands
//   imm8E_i, rsE_i,
//   WriteRegE_i, ALUOpE_i
//   ForwardAE_i/ForwardBE_i  operand select: 01 MEM result, 10 WB result,
//                            00/11 register file
//   WBResultM_i, ResultW_i   forwarded results
//   *E_i control bits        RegWrite, Branch, MemRead, MemWrite,
//                            MemToReg, Mov
//   flush_EX_MEM_i           squash EX (branch taken in MEM)
//   stall_EX_MEM_i           downstream stall; hold EX/MEM and multiplier
//   *M_o                     EX/MEM register outputs
//   mul_busy_o               combinational; stalls IF/ID and ID/EX
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM8_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] rd1E_i,
  input  logic [DATA_WIDTH-1:0] rd2E_i,
  input  logic [IMM8_WIDTH-1:0] imm8E_i,
  input  logic [REG_WIDTH-1:0]  rsE_i,
  input  logic [REG_WIDTH-1:0]  WriteRegE_i,
  input  logic [OP_WIDTH-1:0]   ALUOpE_i,
  input  logic [1:0]            ForwardAE_i,
  input  logic [1:0]            ForwardBE_i,
  input  logic [DATA_WIDTH-1:0] WBResultM_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  RegWriteE_i,
  input  logic                  BranchE_i,
  input  logic                  MemReadE_i,
  input  logic                  MemWriteE_i,
  input  logic                  MemToRegE_i,
  input  logic                  MovE_i,
  input  logic                  flush_EX_MEM_i,
  input  logic                  stall_EX_MEM_i,
  output logic [ADDR_WIDTH-1:0] PCM_o,
  output logic [DATA_WIDTH-1:0] alu_outM_o,
  output logic [DATA_WIDTH-1:0] WriteDataM_o,
  output logic [IMM8_WIDTH-1:0] imm8M_o,
  output logic [REG_WIDTH-1:0]  rsM_o,
  output logic [REG_WIDTH-1:0]  WriteRegM_o,
  output logic                  RegWriteM_o,
  output logic                  BranchM_o,
  output logic                  MemReadM_o,
  output logic                  MemWriteM_o,
  output logic                  MemToRegM_o,
  output logic                  MovM_o,
  output logic                  mul_busy_o
);

  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;

  logic [DATA_WIDTH-1:0] a_op, b_op, alu_res, result_e;
  logic [SHW-1:0]        shamt;
  logic                  is_mul;

  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] rf,
    input logic [DATA_WIDTH-1:0] mem_res,
    input logic [DATA_WIDTH-1:0] wb_res
  );
    case (sel)
      2'b01:   return mem_res;
      2'b10:   return wb_res;
      default: return rf;
    endcase
  endfunction

  assign a_op   = fwd_sel(ForwardAE_i, rd1E_i, WBResultM_i, ResultW_i);
  assign b_op   = fwd_sel(ForwardBE_i, rd2E_i, WBResultM_i, ResultW_i);
  assign shamt  = b_op[SHW-1:0];
  assign is_mul = (ALUOpE_i == OP_WIDTH'(8));

  // NOTE: every signal written in an always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    alu_res = '0;
    case (ALUOpE_i)
      OP_WIDTH'(0): alu_res = a_op + b_op;
      OP_WIDTH'(1): alu_res = a_op - b_op;
      OP_WIDTH'(2): alu_res = a_op & b_op;
      OP_WIDTH'(3): alu_res = a_op | b_op;
      OP_WIDTH'(4): alu_res = a_op ^ b_op;
      OP_WIDTH'(5): alu_res = a_op << shamt;
      OP_WIDTH'(6): alu_res = a_op >> shamt;
      OP_WIDTH'(7): alu_res = DATA_WIDTH'($signed(a_op) >>> shamt);
      OP_WIDTH'(9): alu_res = b_op;
      default:      alu_res = '0;  // MUL result comes from the FSM in DONE
    endcase
  end

  // A flush aborts the multiply immediately, so busy must not hold the
  // front end in the flush cycle.
  assign mul_busy_o = !flush_EX_MEM_i &&
                      (((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY));

  assign result_e = (state_q == S_DONE) ? prod_q : alu_res;

  // Multiplier next state: multiplicand shifts left, multiplier shifts right,
  // product accumulates modulo 2^DATA_WIDTH.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (flush_EX_MEM_i) begin
      state_d = S_IDLE;
    end else if (!stall_EX_MEM_i) begin
      case (state_q)
        S_IDLE: if (is_mul) begin
          mcand_d  = a_op;
          mplier_d = b_op;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
        S_BUSY: begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the multiplier datapath has no reset; it is fully loaded on accept
  // and never observed before that.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

  // EX/MEM pipeline register. Bubbles zero only the controls; data fields
  // hold since nothing downstream consumes them without a control bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      PCM_o        <= '0;
      alu_outM_o   <= '0;
      WriteDataM_o <= '0;
      imm8M_o      <= '0;
      rsM_o        <= '0;
      WriteRegM_o  <= '0;
      {RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o} <= '0;
    end else if (flush_EX_MEM_i || (!stall_EX_MEM_i && mul_busy_o)) begin
      {RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o} <= '0;
    end else if (!stall_EX_MEM_i) begin
      PCM_o        <= PCE_i;
      alu_outM_o   <= result_e;
      WriteDataM_o <= b_op;
      imm8M_o      <= imm8E_i;
      rsM_o        <= rsE_i;
      WriteRegM_o  <= WriteRegE_i;
      {RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o} <=
        {RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i};
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// Expected EX/MEM contents are pushed to a queue when an instruction is
// driven and popped when the DUT captures it.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PCE_i;
  logic [15:0] rd1E_i, rd2E_i;
  logic [7:0]  imm8E_i;
  logic [3:0]  rsE_i, WriteRegE_i, ALUOpE_i;
  logic [1:0]  ForwardAE_i, ForwardBE_i;
  logic [15:0] WBResultM_i, ResultW_i;
  logic        RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i;
  logic        flush_EX_MEM_i, stall_EX_MEM_i;
  logic [7:0]  PCM_o;
  logic [15:0] alu_outM_o, WriteDataM_o;
  logic [7:0]  imm8M_o;
  logic [3:0]  rsM_o, WriteRegM_o;
  logic        RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o;
  logic        mul_busy_o;

  logic [5:0]  ctrl_m;
  assign ctrl_m = {RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o};

  ex_stage dut (
    .clk(clk), .rst(rst),
    .PCE_i(PCE_i), .rd1E_i(rd1E_i), .rd2E_i(rd2E_i), .imm8E_i(imm8E_i),
    .rsE_i(rsE_i), .WriteRegE_i(WriteRegE_i), .ALUOpE_i(ALUOpE_i),
    .ForwardAE_i(ForwardAE_i), .ForwardBE_i(ForwardBE_i),
    .WBResultM_i(WBResultM_i), .ResultW_i(ResultW_i),
    .RegWriteE_i(RegWriteE_i), .BranchE_i(BranchE_i), .MemReadE_i(MemReadE_i),
    .MemWriteE_i(MemWriteE_i), .MemToRegE_i(MemToRegE_i), .MovE_i(MovE_i),
    .flush_EX_MEM_i(flush_EX_MEM_i), .stall_EX_MEM_i(stall_EX_MEM_i),
    .PCM_o(PCM_o), .alu_outM_o(alu_outM_o), .WriteDataM_o(WriteDataM_o),
    .imm8M_o(imm8M_o), .rsM_o(rsM_o), .WriteRegM_o(WriteRegM_o),
    .RegWriteM_o(RegWriteM_o), .BranchM_o(BranchM_o), .MemReadM_o(MemReadM_o),
    .MemWriteM_o(MemWriteM_o), .MemToRegM_o(MemToRegM_o), .MovM_o(MovM_o),
    .mul_busy_o(mul_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [7:0]  imm;
    logic [3:0]  rs;
    logic [3:0]  wr;
    logic [5:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_fwd(input logic [1:0] sel, input logic [15:0] rf);
    if (sel == 2'b01) return WBResultM_i;
    if (sel == 2'b10) return ResultW_i;
    return rf;
  endfunction

  function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] p;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[3:0];
      4'd6: return a >> b[3:0];
      4'd7: return 16'($signed(a) >>> b[3:0]);
      4'd8: begin p = 32'(a) * 32'(b); return p[15:0]; end
      4'd9: return b;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [5:0] c);
    {RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i} = c;
  endtask

  task automatic rand_fields();
    PCE_i       = 8'($urandom);
    imm8E_i     = 8'($urandom);
    rsE_i       = 4'($urandom);
    WriteRegE_i = 4'($urandom);
  endtask

  function automatic exp_t make_exp(input logic [5:0] c);
    exp_t e;
    logic [15:0] a, b;
    a = model_fwd(ForwardAE_i, rd1E_i);
    b = model_fwd(ForwardBE_i, rd2E_i);
    e.pc = PCE_i; e.alu = model_alu(ALUOpE_i, a, b); e.wd = b;
    e.imm = imm8E_i; e.rs = rsE_i; e.wr = WriteRegE_i; e.ctrl = c;
    return e;
  endfunction

  // Single-cycle instruction: drive, push expectation, one edge, pop, compare.
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [15:0] wbm, input logic [15:0] resw, input logic [5:0] c);
    exp_t e;
    ALUOpE_i = op; rd1E_i = r1; rd2E_i = r2; ForwardAE_i = fa; ForwardBE_i = fb;
    WBResultM_i = wbm; ResultW_i = resw; set_ctrl(c); rand_fields();
    exp_q.push_back(make_exp(c));
    tick();
    e = exp_q.pop_front();
    check({tag, "_alu"},  alu_outM_o,   e.alu);
    check({tag, "_wd"},   WriteDataM_o, e.wd);
    check({tag, "_ctrl"}, ctrl_m,       e.ctrl);
    check({tag, "_pc"},   PCM_o,        e.pc);
    check({tag, "_flds"}, {imm8M_o, rsM_o, WriteRegM_o}, {e.imm, e.rs, e.wr});
  endtask

  // MUL with optional stall window [stall_at, stall_at+stall_len) counted in
  // cycles from the accept cycle.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int stall_at, input int stall_len);
    exp_t e;
    int   busy_cnt;
    bit   done, was_busy, was_stall;
    logic [15:0] snap_alu;
    logic [5:0]  snap_ctrl;
    logic [5:0]  c;
    c = 6'($urandom_range(1, 63));
    ALUOpE_i = 4'd8; rd1E_i = a; rd2E_i = b; ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
    set_ctrl(c); rand_fields();
    exp_q.push_back(make_exp(c));
    busy_cnt = 0; done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      stall_EX_MEM_i = (stall_at >= 0 && k >= stall_at && k < stall_at + stall_len);
      if (k == 1) begin
        rd1E_i = 16'($urandom);  // operands were latched at accept
        rd2E_i = 16'($urandom);
      end
      #1;
      was_busy  = mul_busy_o;
      was_stall = stall_EX_MEM_i;
      snap_alu  = alu_outM_o;
      snap_ctrl = ctrl_m;
      if (was_busy) busy_cnt++;
      tick();
      if (was_stall) begin
        check({tag, "_stall_hold"}, {alu_outM_o, ctrl_m}, {snap_alu, snap_ctrl});
      end else if (was_busy) begin
        check({tag, "_bubble_ctrl"}, ctrl_m, 6'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_prod"}, alu_outM_o, e.alu);
        check({tag, "_ctrl"}, ctrl_m, e.ctrl);
        check({tag, "_pc"},   PCM_o,  e.pc);
        done = 1'b1;
      end
    end
    stall_EX_MEM_i = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    check({tag, "_busy_cycles"}, busy_cnt, (stall_at >= 0) ? 17 + stall_len : 17);
  endtask

  initial begin
    rst = 1'b1; flush_EX_MEM_i = 1'b0; stall_EX_MEM_i = 1'b0;
    ALUOpE_i = 4'd0; rd1E_i = '0; rd2E_i = '0; ForwardAE_i = '0; ForwardBE_i = '0;
    WBResultM_i = '0; ResultW_i = '0; set_ctrl(6'd0); rand_fields();
    tick(); tick();
    check("reset_data", {PCM_o, alu_outM_o, WriteDataM_o, imm8M_o, rsM_o, WriteRegM_o}, 0);
    check("reset_wd",   WriteDataM_o, 16'h0);
    check("reset_ctrl", ctrl_m, 6'd0);
    check("reset_busy", mul_busy_o, 1'b0);
    rst = 1'b0;

    issue("add_wrap", 4'd0, 16'h7FFF, 16'h0001, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);
    issue("and_fwd",  4'd2, 16'h0000, 16'hAAAA, 2'b01, 2'b10, 16'h1234, 16'h0F0F, 6'b100001);
    issue("sub_wrap", 4'd1, 16'h0000, 16'h0001, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);
    issue("sra",      4'd7, 16'h8000, 16'h0004, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);
    issue("srl",      4'd6, 16'h8000, 16'hFFF4, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);
    issue("sll_15",   4'd5, 16'h0003, 16'h000F, 2'b11, 2'b11, 16'h0, 16'h0, 6'b010000);
    issue("passb",    4'd9, 16'h1111, 16'h2222, 2'b00, 2'b01, 16'hBEEF, 16'h0, 6'b000101);
    issue("op_15",    4'd15, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8) op = 4'd9;
      issue("rand", op, 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom),
            16'($urandom), 16'($urandom), 6'($urandom));
    end

    run_mul("mul_3xffff", 16'h0003, 16'hFFFF, -1, 0);
    run_mul("mul_b2b",    16'h1234, 16'h0056, -1, 0);
    run_mul("mul_stall",  16'h00FF, 16'h0101, 5, 3);
    run_mul("mul_neg",    16'h8001, 16'h8001, -1, 0);

    // Flush in the fifth busy cycle aborts the MUL.
    ALUOpE_i = 4'd8; rd1E_i = 16'h0005; rd2E_i = 16'h0007; ForwardAE_i = 2'b00;
    ForwardBE_i = 2'b00; set_ctrl(6'b100000);
    for (int k = 0; k < 5; k++) tick();
    flush_EX_MEM_i = 1'b1;
    #1;
    check("flush_busy_drop", mul_busy_o, 1'b0);
    tick();
    check("flush_ctrl", ctrl_m, 6'd0);
    flush_EX_MEM_i = 1'b0;
    issue("post_flush_add", 4'd0, 16'h0010, 16'h0020, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);

    // Reset mid-MUL.
    ALUOpE_i = 4'd8; rd1E_i = 16'h0009; rd2E_i = 16'h0009; set_ctrl(6'b100000);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1; ALUOpE_i = 4'd10;
    tick();
    check("rst_mid_data", {PCM_o, alu_outM_o, WriteDataM_o, imm8M_o, rsM_o, WriteRegM_o}, 0);
    check("rst_mid_wd",   WriteDataM_o, 16'h0);
    check("rst_mid_ctrl", ctrl_m, 6'd0);
    check("rst_mid_busy", mul_busy_o, 1'b0);
    rst = 1'b0;
    issue("op10_zero", 4'd10, 16'h1234, 16'h5678, 2'b00, 2'b00, 16'h0, 16'h0, 6'b100000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
